stoch_arith_core: RTL and testbench

Parametrised stochastic-computing arithmetic unit: converts two WIDTH-bit unsigned operands into pseudo-random bitstreams, combines them bitwise according to a selectable mode, and counts the ones to produce a WIDTH-bit binary result. It generalises the 8-bit single-function stochastic multiplier to any width and adds scaled addition and bipolar multiplication behind a start/done handshake. It sits between the TinyTapeout top-level pin wrapper and the operand/result registers.

---
 rtl/stoch_pkg.sv | 61 ++++++
 rtl/stoch_lfsr.sv | 64 ++++++
 rtl/stoch_arith_core.sv | 175 +++++++++++++++++
 tb/tb_stoch_arith_core.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stoch_pkg.sv
// -----------------------------------------------------------------------------
// stoch_pkg
//
// Shared definitions for the stochastic arithmetic core:
//   - mode_e  : operation selected at start (AND multiply, MUX scaled add,
//               XNOR bipolar multiply, reserved code treated as multiply)
//   - state_e : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   - lfsr_taps() : feedback mask of a maximal-length Fibonacci LFSR for
//                   widths 4..16 (bit k set = stage k+1 is tapped)
//   - seed_fix()  : trims a seed to the register width and replaces an
//                   all-zero seed (the LFSR lock-up state) with 1
// -----------------------------------------------------------------------------
package stoch_pkg;

    localparam int unsigned MIN_WIDTH = 4;
    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_BMUL = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Maximal-length taps for a left-shifting Fibonacci register whose
    // feedback enters bit 0 and whose oldest stage is the MSB.
    function automatic logic [15:0] lfsr_taps(input int unsigned width);
        case (width)
            4:       return 16'h000C;  // x^4  + x^3  + 1
            5:       return 16'h0014;  // x^5  + x^3  + 1
            6:       return 16'h0030;  // x^6  + x^5  + 1
            7:       return 16'h0060;  // x^7  + x^6  + 1
            8:       return 16'h00B8;  // x^8  + x^6  + x^5 + x^4 + 1
            9:       return 16'h0110;  // x^9  + x^5  + 1
            10:      return 16'h0240;  // x^10 + x^7  + 1
            11:      return 16'h0500;  // x^11 + x^9  + 1
            12:      return 16'h0829;  // x^12 + x^6  + x^4 + x + 1
            13:      return 16'h100D;  // x^13 + x^4  + x^3 + x + 1
            14:      return 16'h2015;  // x^14 + x^5  + x^3 + x + 1
            15:      return 16'h6000;  // x^15 + x^14 + 1
            16:      return 16'hD008;  // x^16 + x^15 + x^13 + x^4 + 1
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] seed_fix(input int unsigned width,
                                             input logic [15:0] seed);
        logic [15:0] mask;
        logic [15:0] masked;
        mask   = 16'hFFFF >> (16 - width);
        masked = seed & mask;
        return (masked == 16'h0000) ? 16'h0001 : masked;
    endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// -----------------------------------------------------------------------------
// stoch_lfsr
//
// WIDTH-bit maximal-length Fibonacci LFSR. Visits every nonzero value exactly
// once per 2^WIDTH - 1 steps, which is what makes the stochastic streams
// carry an exact number of ones.
//
// Parameters:
//   WIDTH : register width, 4..16
//   SEED  : start value (trimmed to WIDTH; zero replaced by 1)
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset, returns register to SEED
//   load  in   reload SEED (has priority over en)
//   en    in   advance one step
//   state out  current register value
// -----------------------------------------------------------------------------
module stoch_lfsr
    import stoch_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter logic [15:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [WIDTH-1:0] state
);

    localparam logic [15:0]      TAPS_FULL = lfsr_taps(WIDTH);
    localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];
    localparam logic [15:0]      SEED_FULL = seed_fix(WIDTH, SEED);
    localparam logic [WIDTH-1:0] SEED_W    = SEED_FULL[WIDTH-1:0];

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic             feedback;

    // NOTE: every variable gets a value before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        feedback = ^(state_q & TAPS);
        state_d  = state_q;
        if (load) begin
            state_d = SEED_W;
        end else if (en) begin
            state_d = {state_q[WIDTH-2:0], feedback};
        end
    end

    // NOTE: registers are updated with non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED_W;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/stoch_arith_core.sv
// -----------------------------------------------------------------------------
// stoch_arith_core
//
// Stochastic-computing arithmetic unit. On start it latches two unsigned
// operands and a mode, then for L = 2^WIDTH - 1 cycles turns each operand
// into one stream bit per cycle by comparing it against an LFSR value,
// combines the two bits according to the mode, and counts the ones. The
// count is published as the result together with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  : operand/result width, 4..16
//   SEED_A : seed of the stream-A LFSR (zero replaced by 1)
//   SEED_B : seed of the stream-B LFSR (zero replaced by 1)
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset; aborts any computation
//   start   in   request, only sampled while idle
//   mode    in   00 AND multiply, 01 MUX scaled add, 10 XNOR bipolar
//                multiply, 11 treated as 00
//   a, b    in   unsigned operands, latched on accepted start
//   busy    out  high while running or presenting the result
//   done    out  one-cycle pulse, result valid
//   result  out  ones count of the output stream, held until next done
// -----------------------------------------------------------------------------
module stoch_arith_core
    import stoch_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter logic [15:0] SEED_A = 16'h0001,
    parameter logic [15:0] SEED_B = 16'h005A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Counter value of the final stream bit: L - 1 = 2^WIDTH - 2.
    localparam logic [WIDTH-1:0] LAST_BIT = ~WIDTH'(1);

    state_e           state_q,  state_d;
    mode_e            mode_q,   mode_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] ones_q,   ones_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             accept;
    logic             run;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [WIDTH-1:0] lfsr_b_rev;
    logic             sa;
    logic             sb;
    logic             y;
    logic [WIDTH-1:0] ones_sum;

    assign accept = (state_q == ST_IDLE) && start;
    assign run    = (state_q == ST_RUN);

    // Both generators restart from their seeds on every accepted request so
    // a given operand pair always produces the same result.
    stoch_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED_A)
    ) u_lfsr_a (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .en    (run),
        .state (lfsr_a)
    );

    stoch_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED_B)
    ) u_lfsr_b (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .en    (run),
        .state (lfsr_b)
    );

    // Reversing B's bits decorrelates it from A, which runs the same
    // polynomial; reversal is a bijection on nonzero values, so B's stream
    // still carries exactly b ones per period.
    assign lfsr_b_rev = {<<{lfsr_b}};

    // The LFSR never holds zero, so value-1 spans 0..L-1 exactly once per
    // period and the comparison is true on exactly a (resp. b) cycles.
    assign sa = (lfsr_a     - WIDTH'(1)) < a_q;
    assign sb = (lfsr_b_rev - WIDTH'(1)) < b_q;

    always_comb begin
        case (mode_q)
            MODE_ADD:  y = cnt_q[0] ? sb : sa;  // alternate select: (a+b)/2
            MODE_BMUL: y = ~(sa ^ sb);
            default:   y = sa & sb;             // MODE_MUL and MODE_RSVD
        endcase
    end

    // At most L ones are counted, which fits in WIDTH bits.
    assign ones_sum = ones_q + {{(WIDTH-1){1'b0}}, y};

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        ones_d   = ones_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode_e'(mode);
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    ones_d  = '0;
                end
            end
            ST_RUN: begin
                cnt_d  = cnt_q + WIDTH'(1);
                ones_d = ones_sum;
                if (cnt_q == LAST_BIT) begin
                    // Publish including the final bit so result is valid in
                    // the same cycle that done is raised.
                    state_d  = ST_DONE;
                    result_d = ones_sum;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_MUL;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            ones_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            ones_q   <= ones_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_stoch_arith_core.sv
// -----------------------------------------------------------------------------
// tb_stoch_arith_core
//
// Scoreboard bench for stoch_arith_core at WIDTH=8. The driver pushes the
// expected result and done cycle for each accepted request; an independent
// monitor pops and compares whenever done is seen. Expected values come from
// counting stream ones over one full LFSR period using plain integer math.
// -----------------------------------------------------------------------------
module tb_stoch_arith_core;

    localparam int W = 8;
    localparam int L = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [W-1:0] last_res = '0;

    typedef struct {
        logic [W-1:0] res;
        int           due;
        int           req;
        int           tol;
        string        tag;
    } exp_t;

    exp_t sb_q[$];

    // Per-cycle LFSR values: stream A as-is, stream B already bit-reversed.
    int seq_a [L];
    int seq_b [L];

    stoch_arith_core #(
        .WIDTH  (W),
        .SEED_A (16'h0001),
        .SEED_B (16'h005A)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #950000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- model
    // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
    function automatic int step8(input int s);
        int fb;
        fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
        return ((s << 1) & 'hFF) | fb;
    endfunction

    function automatic int rev8(input int s);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) begin
            if (((s >> i) & 1) != 0) r = r | (1 << (7 - i));
        end
        return r;
    endfunction

    function automatic int model(input int av, input int bv, input int md);
        int ones;
        bit sa;
        bit sb;
        bit y;
        ones = 0;
        for (int k = 0; k < L; k++) begin
            sa = (seq_a[k] - 1) < av;
            sb = (seq_b[k] - 1) < bv;
            case (md)
                1:       y = (k % 2 == 1) ? sb : sa;
                2:       y = (sa == sb);
                default: y = sa & sb;
            endcase
            ones = ones + int'(y);
        end
        return ones;
    endfunction

    // ---------------------------------------------------------------- check
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 || sb_q.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 2 * L + 20) begin
                checks++;
                failures++;
                $display("FAIL wait_idle: busy=%0b pending=%0d after %0d cycles, required idle",
                         busy, sb_q.size(), n);
                sb_q.delete();
                return;
            end
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input string tag, input bit push, input int req, input int tol);
        exp_t e;
        @(negedge clk);
        wait_idle();
        start = 1'b1;
        mode  = m;
        a     = av;
        b     = bv;
        if (push) begin
            e.res = W'(model(int'(av), int'(bv), int'(m)));
            e.due = cyc + L + 1;
            e.req = req;
            e.tol = tol;
            e.tag = tag;
            sb_q.push_back(e);
        end
        @(negedge clk);
        // Operand changes while busy must have no effect.
        start = 1'b0;
        mode  = 2'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_held"}, 32'(result), 32'(last_res));
    endtask

    // Keep start high with random operands through RUN and the DONE cycle.
    task automatic hammer_until_done(input string tag);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            mode  = 2'($urandom);
            if (done === 1'b1) break;
            n++;
            if (n > L + 10) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout: done not seen within %0d cycles, required done", tag, L + 10);
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // -------------------------------------------------------------- monitor
    initial begin
        exp_t e;
        int   diff;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: done at cycle %0d with result %0d, required no done",
                             cyc, result);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_result"},  32'(result), 32'(e.res));
                    check({e.tag, "_latency"}, 32'(cyc),    32'(e.due));
                    check({e.tag, "_busy_at_done"}, 32'(busy), 32'd1);
                    if (e.req >= 0) begin
                        diff = int'(result) - e.req;
                        if (diff < 0) diff = -diff;
                        checks++;
                        if (diff > e.tol) begin
                            failures++;
                            $display("FAIL %s_value: got %0d, required %0d +/- %0d",
                                     e.tag, result, e.req, e.tol);
                        end
                    end
                    last_res = e.res;
                end
            end
        end
    end

    // ----------------------------------------------------------------- main
    initial begin
        int sbv;
        logic [1:0] m;

        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        a     = '0;
        b     = '0;

        seq_a[0] = 1;
        for (int k = 1; k < L; k++) seq_a[k] = step8(seq_a[k-1]);
        sbv = 'h5A;
        for (int k = 0; k < L; k++) begin
            seq_b[k] = rev8(sbv);
            sbv      = step8(sbv);
        end

        // Reset state, with start held high during reset.
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'd77;
        b     = 8'd99;
        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_result", 32'(result), 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        // Directed points.
        issue(2'b00, 8'd200, 8'd255, "mul_200_255", 1'b1, 200, 0);
        issue(2'b00, 8'd0,   8'd173, "mul_0_173",   1'b1, 0,   0);
        issue(2'b00, 8'd255, 8'd255, "mul_255_255", 1'b1, 255, 0);
        hammer_until_done("busy_start");
        issue(2'b01, 8'd200, 8'd200, "add_200_200", 1'b1, -1,  0);
        issue(2'b01, 8'd255, 8'd0,   "add_255_0",   1'b1, 128, 1);
        issue(2'b10, 8'd255, 8'd255, "bmul_255_255", 1'b1, 255, 0);
        issue(2'b10, 8'd255, 8'd0,   "bmul_255_0",  1'b1, 0,   0);
        issue(2'b10, 8'd100, 8'd180, "bmul_100_180", 1'b1, -1,  0);
        issue(2'b11, 8'd200, 8'd255, "rsvd_200_255", 1'b1, 200, 0);
        issue(2'b00, 8'd1,   8'd255, "mul_1_255",   1'b1, 1,   0);

        // Reset around the 100th stream bit: abort with no done, result 0.
        issue(2'b00, 8'd123, 8'd77, "abort", 1'b0, -1, 0);
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_done",   32'(done),   32'd0);
        check("abort_result", 32'(result), 32'd0);
        rst      = 1'b0;
        last_res = '0;
        issue(2'b00, 8'd150, 8'd200, "post_abort", 1'b1, -1, 0);

        // Random sweep, mostly multiply, some of every mode.
        for (int i = 0; i < 200; i++) begin
            m = (i < 160) ? 2'b00 : 2'($urandom_range(0, 3));
            issue(m, W'($urandom), W'($urandom), $sformatf("rand%0d", i), 1'b1, -1, 0);
        end

        // Drain, then allow time for any spurious extra done to show up.
        @(negedge clk);
        wait_idle();
        repeat (L + 10) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
